mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline, directly downstream of exe_stage. Latches es_to_ms_bus and
//  completes loads against a variable-latency data SRAM response channel (data_ok/rdata). Forwards
//  results to ID, reports its own exception to EXE so stores are squashed, and passes results to WB.
//  Flushes on ex_from_ws and drops responses that belong to flushed loads.
// PARAMETERS
//  DISCARD_CNT_W  2  width of the stale-response discard counter (max outstanding killed loads = 2^W-1)
// PORTS
//  clk              in   1    clock; all state updates on posedge
//  reset            in   1    synchronous, active-high reset
//  ws_allowin       in   1    WB can accept this cycle
//  ms_allowin       out  1    MEM can accept from EXE this cycle
//  es_to_ms_valid   in   1    EXE presents a valid instruction
//  es_to_ms_bus     in   `ES_TO_MS_BUS_WD (117)  {mem_req,mtc0_we,cp0_addr[4:0],ex,excode[4:0],
//                             res_from_cp0,res_from_mem,gr_we,dest[4:0],alu_result[31:0],rt_value[31:0],pc[31:0]}
//  ms_to_ws_valid   out  1    valid instruction leaving MEM
//  ms_to_ws_bus     out  `MS_TO_WS_BUS_WD (147)  {mtc0_we,cp0_addr,ex,excode,badvaddr[31:0],
//                             res_from_cp0,gr_we,dest,final_result[31:0],rt_value[31:0],pc[31:0]}
//  ms_to_es_bus     out  `MS_TO_ES_BUS_WD (1)    ex_from_cur_ms = ms_valid & ms_ex
//  ms_to_ds_bus     out  `MS_TO_DS_BUS_WD (39)   {fwd_valid,fwd_stall,fwd_dest[4:0],fwd_data[31:0]}
//  data_sram_data_ok in  1    one-cycle pulse: read/write response returned, in request order
//  data_sram_rdata  in   32   read data, valid when data_sram_data_ok=1
//  ex_from_ws       in   1    exception/eret committed in WB: flush MEM
// BEHAVIOUR
//  - Reset: ms_valid=0, buf_valid=0, discard_cnt=0 => ms_to_ws_valid=0, ms_to_es_bus=0, fwd_valid=0,
//    fwd_stall=0, ms_allowin=1. bus register is don't-care while ms_valid=0.
//  - Latch: es_to_ms_valid & ms_allowin -> bus_r <= es_to_ms_bus, buf_valid<=0. ms_valid updates when
//    ms_allowin: ms_valid <= es_to_ms_valid. reset or ex_from_ws forces ms_valid<=0 (priority over latch).
//  - Entry FSM (per held instruction): NOREQ (mem_req=0: ready_go=1 at once) | WAIT (mem_req=1, no data)
//    | DONE (buf_valid=1). WAIT->DONE on data_ok while discard_cnt==0: rdata captured into rdata_buf.
//    ms_ready_go = ~mem_req | buf_valid | (data_ok & discard_cnt==0) (same-cycle bypass of rdata).
//  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
//  - final_result = res_from_mem ? (buf_valid ? rdata_buf : data_sram_rdata) : alu_result.
//    Stores (mem_req & ~res_from_mem) also wait for their data_ok; rdata ignored.
//  - badvaddr = alu_result (meaningful only for excode 4/5); ex, excode passed through unchanged.
//  - Discard: on the flush cycle, killed = (ms_valid & mem_req & ~buf_valid & ~(data_ok & discard_cnt==0))
//    + (es_to_ms_valid & es mem_req & ms_allowin). discard_cnt <= discard_cnt + killed - consumed, where
//    consumed = data_ok & discard_cnt!=0. While discard_cnt!=0 every data_ok is swallowed, never used.
//    Overflow past 2^W-1 is a design error: assertion fires, counter saturates.
//  - Forwarding: fwd_valid = ms_valid & gr_we & ~ex & dest!=0; fwd_stall = fwd_valid & (res_from_cp0 |
//    (res_from_mem & ~ms_ready_go)); fwd_data = final_result.
//  - Simultaneous ex_from_ws and ws_allowin: flush wins; outgoing instruction is not re-presented.
//  - data_ok with ms_valid=0 and discard_cnt==0 is illegal (assertion).
// STRUCTURE
//  - mycpu.h: ES_TO_MS/MS_TO_WS/MS_TO_ES/MS_TO_DS bus widths, EXC_ADEL=5'h04, EXC_ADES=5'h05, EXC_OV=5'h0c.
//  - Single flat module; discard counter inline (no sub-module warranted).
// TESTING
//  1 reset held 3 cycles -> ms_to_ws_valid=0, ms_allowin=1, ms_to_ds_bus=0 throughout.
//  2 lw, alu_result=0x100, data_ok 3 cycles later with rdata=0xDEADBEEF -> ready_go=0 for 2 cycles,
//    fwd_stall=1, then final_result=0xDEADBEEF same cycle as data_ok.
//  3 lw, data_ok arrives while ws_allowin=0 -> rdata buffered; next cycle rdata changes to 0x0 and
//    ws_allowin=1 -> final_result still 0xDEADBEEF.
//  4 lw in WAIT + lw entering from EXE when ex_from_ws=1 -> discard_cnt=2, next two data_ok swallowed,
//    third data_ok completes the next new load.
//  5 addu result 0x5, dest=8 -> fwd_valid=1, fwd_stall=0, fwd_data=0x5; dest=0 -> fwd_valid=0.
//  6 es_to_ms_bus with ex=1, excode=5'h04, alu_result=0x101 -> ms_to_es_bus=1, ms_to_ws_bus.ex=1,
//    excode=0x04, badvaddr=0x101, fwd_valid=0, ready_go=1 immediately (mem_req=0).

Source files
------------

// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Purpose : bus widths, exception codes, bus payload layouts and entry-state
//           encoding shared by the MEM stage of the 5-stage MIPS pipeline.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int unsigned ES_TO_MS_BUS_WD = 117;
   localparam int unsigned MS_TO_WS_BUS_WD = 147;
   localparam int unsigned MS_TO_ES_BUS_WD = 1;
   localparam int unsigned MS_TO_DS_BUS_WD = 39;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   // Instruction payload handed over by EXE (MSB first)
   typedef struct packed {
      logic        mem_req;
      logic        mtc0_we;
      logic [4:0]  cp0_addr;
      logic        ex;
      logic [4:0]  excode;
      logic        res_from_cp0;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] rt_value;
      logic [31:0] pc;
   } es_to_ms_t;

   // Instruction payload handed on to WB (MSB first)
   typedef struct packed {
      logic        mtc0_we;
      logic [4:0]  cp0_addr;
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] badvaddr;
      logic        res_from_cp0;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] rt_value;
      logic [31:0] pc;
   } ms_to_ws_t;

   // Forwarding information for the ID stage
   typedef struct packed {
      logic        fwd_valid;
      logic        fwd_stall;
      logic [4:0]  fwd_dest;
      logic [31:0] fwd_data;
   } ms_to_ds_t;

   // Progress of the instruction currently held in MEM
   typedef enum logic [1:0] {
      ENT_NOREQ = 2'd0,   // no memory access: ready at once
      ENT_WAIT  = 2'd1,   // access issued, response not yet seen
      ENT_DONE  = 2'd2    // response captured in the read-data buffer
   } entry_st_e;

endpackage

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Purpose : MEM stage of the 5-stage MIPS pipeline. Holds one instruction from
//           EXE, completes loads/stores against an in-order, variable-latency
//           data SRAM response channel, forwards results to ID, reports its
//           exception to EXE and hands results to WB. A flush from WB drops
//           the held instruction and swallows responses of killed accesses.
// Ports   :
//   clk, reset          clock / synchronous active-high reset
//   ws_allowin          WB can accept this cycle
//   ms_allowin          MEM can accept from EXE this cycle
//   es_to_ms_valid/bus  instruction from EXE
//   ms_to_ws_valid/bus  instruction to WB
//   ms_to_es_bus        exception present in MEM (squashes EXE stores)
//   ms_to_ds_bus        {fwd_valid, fwd_stall, fwd_dest, fwd_data} to ID
//   data_sram_data_ok   one-cycle response pulse, in request order
//   data_sram_rdata     read data qualified by data_sram_data_ok
//   ex_from_ws          exception/eret committed in WB: flush MEM
// ----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DISCARD_CNT_W = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
   output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   input  logic                       ex_from_ws
);

   localparam int unsigned CNT_SUM_W = DISCARD_CNT_W + 2;
   localparam int unsigned CNT_MAX   = (1 << DISCARD_CNT_W) - 1;

   logic                     r_ms_valid;
   logic                     r_buf_valid;
   logic [31:0]              r_rdata_buf;
   es_to_ms_t                r_bus;
   logic [DISCARD_CNT_W-1:0] r_discard_cnt;

   es_to_ms_t                w_es;
   ms_to_ws_t                w_ws;
   ms_to_ds_t                w_ds;
   entry_st_e                w_entry_st;
   logic                     w_cnt_zero;
   logic                     w_data_hit;
   logic                     w_ready_go;
   logic                     w_accept;
   logic                     w_capture;
   logic                     w_kill_ms;
   logic                     w_kill_es;
   logic                     w_consumed;
   logic [CNT_SUM_W-1:0]     w_cnt_sum;
   logic                     w_cnt_ovf;
   logic [DISCARD_CNT_W-1:0] w_cnt_next;
   logic [31:0]              w_final_result;
   logic                     w_fwd_valid;

   assign w_es = es_to_ms_t'(es_to_ms_bus);

   // Progress of the held instruction, derived from its request flag and buffer
   always_comb begin
      w_entry_st = ENT_NOREQ;
      if (r_bus.mem_req) begin
         w_entry_st = r_buf_valid ? ENT_DONE : ENT_WAIT;
      end
   end

   // A response belongs to the held instruction only when no killed access is pending
   assign w_cnt_zero = (r_discard_cnt == '0);
   assign w_data_hit = data_sram_data_ok & w_cnt_zero;
   assign w_consumed = data_sram_data_ok & ~w_cnt_zero;

   // The response cycle itself completes the instruction (rdata bypass)
   assign w_ready_go     = (w_entry_st != ENT_WAIT) | w_data_hit;
   assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
   assign ms_to_ws_valid = r_ms_valid & w_ready_go;
   assign w_accept       = es_to_ms_valid & ms_allowin;
   assign w_capture      = r_ms_valid & (w_entry_st == ENT_WAIT) & w_data_hit;

   // Accesses whose responses are still to come when a flush removes their owner
   assign w_kill_ms = ex_from_ws & r_ms_valid & (w_entry_st == ENT_WAIT) & ~w_data_hit;
   assign w_kill_es = ex_from_ws & w_accept & w_es.mem_req;

   // Wide sum so an overflow is visible before saturating
   assign w_cnt_sum  = CNT_SUM_W'(r_discard_cnt) + CNT_SUM_W'(w_kill_ms)
                     + CNT_SUM_W'(w_kill_es) - CNT_SUM_W'(w_consumed);
   assign w_cnt_ovf  = (w_cnt_sum > CNT_SUM_W'(CNT_MAX));
   assign w_cnt_next = w_cnt_ovf ? '1 : w_cnt_sum[DISCARD_CNT_W-1:0];

   assign w_final_result = r_bus.res_from_mem
                         ? (r_buf_valid ? r_rdata_buf : data_sram_rdata)
                         : r_bus.alu_result;

   // Outgoing WB payload
   always_comb begin
      w_ws              = '0;
      w_ws.mtc0_we      = r_bus.mtc0_we;
      w_ws.cp0_addr     = r_bus.cp0_addr;
      w_ws.ex           = r_bus.ex;
      w_ws.excode       = r_bus.excode;
      w_ws.badvaddr     = r_bus.alu_result;
      w_ws.res_from_cp0 = r_bus.res_from_cp0;
      w_ws.gr_we        = r_bus.gr_we;
      w_ws.dest         = r_bus.dest;
      w_ws.final_result = w_final_result;
      w_ws.rt_value     = r_bus.rt_value;
      w_ws.pc           = r_bus.pc;
   end

   // Forwarding: a result not yet known (cp0 read, pending load) stalls ID
   assign w_fwd_valid = r_ms_valid & r_bus.gr_we & ~r_bus.ex & (r_bus.dest != 5'd0);

   always_comb begin
      w_ds           = '0;
      w_ds.fwd_valid = w_fwd_valid;
      w_ds.fwd_stall = w_fwd_valid & (r_bus.res_from_cp0 | (r_bus.res_from_mem & ~w_ready_go));
      w_ds.fwd_dest  = r_bus.dest;
      w_ds.fwd_data  = w_final_result;
   end

   assign ms_to_ws_bus = MS_TO_WS_BUS_WD'(w_ws);
   assign ms_to_ds_bus = MS_TO_DS_BUS_WD'(w_ds);
   assign ms_to_es_bus = MS_TO_ES_BUS_WD'(r_ms_valid & r_bus.ex);

   // Stage state; flush has priority over accepting a new instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ms_valid    <= 1'b0;
         r_buf_valid   <= 1'b0;
         r_rdata_buf   <= 32'd0;
         r_bus         <= '0;
         r_discard_cnt <= '0;
      end else begin
         if (ex_from_ws) begin
            r_ms_valid <= 1'b0;
         end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
         end

         if (w_accept) begin
            r_bus       <= w_es;
            r_buf_valid <= 1'b0;
         end else if (w_capture) begin
            r_buf_valid <= 1'b1;
         end

         if (w_capture) begin
            r_rdata_buf <= data_sram_rdata;
         end

         r_discard_cnt <= w_cnt_next;
      end
   end

   // A response with nobody waiting for it and nothing to discard
   a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
      !(data_sram_data_ok && !r_ms_valid && w_cnt_zero));

   // More killed accesses in flight than the discard counter can track
   a_no_discard_ovf : assert property (@(posedge clk) disable iff (reset)
      !w_cnt_ovf);

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Purpose : self-checking bench for mem_stage. A driver issues instructions,
//           WB back-pressure, flushes and in-order SRAM responses; a monitor
//           keeps a queue-level model of the stage (held instruction, pending
//           responses, killed responses) and compares every cycle.
// ----------------------------------------------------------------------------
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         ws_allowin;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [116:0] es_to_ms_bus;
   logic         ms_to_ws_valid;
   logic [146:0] ms_to_ws_bus;
   logic [0:0]   ms_to_es_bus;
   logic [38:0]  ms_to_ds_bus;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         ex_from_ws;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_to_es_bus      (ms_to_es_bus),
      .ms_to_ds_bus      (ms_to_ds_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ex_from_ws        (ex_from_ws)
   );

   // fl: 1 = flush the cycle after acceptance, 2 = flush while presented
   typedef struct {
      bit        mem_req, mtc0_we, ex, res_from_cp0, res_from_mem, gr_we;
      bit [4:0]  cp0_addr, excode, dest;
      bit [31:0] alu, rt, pc, rdata;
      int        lat, wsl, fl;
   } ins_t;

   typedef struct {
      bit        live;
      bit [31:0] rdata;
      int        issue;
      int        lat;
   } rsp_t;

   ins_t exp_q[$];
   ins_t dir_q[$];
   rsp_t sram_q[$];
   ins_t cur;
   bit   head_got;
   bit   acc_flag;
   int   cyc;
   int   n_chk;
   int   n_fail;
   int   ws_low;
   int   ws_pct, flush_pct, idle_pct, lat_max;

   function automatic logic [116:0] es_bus(input ins_t i);
      return {i.mem_req, i.mtc0_we, i.cp0_addr, i.ex, i.excode, i.res_from_cp0,
              i.res_from_mem, i.gr_we, i.dest, i.alu, i.rt, i.pc};
   endfunction

   function automatic logic [31:0] fin(input ins_t i);
      return i.res_from_mem ? i.rdata : i.alu;
   endfunction

   function automatic logic [146:0] ws_bus(input ins_t i);
      return {i.mtc0_we, i.cp0_addr, i.ex, i.excode, i.alu, i.res_from_cp0,
              i.gr_we, i.dest, fin(i), i.rt, i.pc};
   endfunction

   function automatic ins_t base(input bit [31:0] alu, input bit [4:0] dest);
      ins_t i;
      i = '{default: 0};
      i.alu  = alu;
      i.dest = dest;
      i.rt   = $urandom;
      i.pc   = $urandom & 32'hffff_fffc;
      return i;
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      logic [4:0] codes [3];
      codes = '{5'h04, 5'h05, 5'h0c};
      i = base($urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      i.cp0_addr = 5'($urandom);
      i.rdata    = ($urandom_range(0, 3) == 0) ? 32'hdead_beef : $urandom;
      i.lat      = $urandom_range(0, lat_max);
      case ($urandom_range(0, 5))
         0: i.gr_we = 1'b1;
         1: begin i.mem_req = 1'b1; i.res_from_mem = 1'b1; i.gr_we = 1'b1; end
         2: i.mem_req = 1'b1;
         3: begin i.ex = 1'b1; i.excode = codes[$urandom_range(0, 2)]; i.gr_we = 1'($urandom); end
         4: begin i.res_from_cp0 = 1'b1; i.gr_we = 1'b1; end
         default: i.mtc0_we = 1'b1;
      endcase
      return i;
   endfunction

   task automatic chk(input string nm, input logic [146:0] act, input logic [146:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor / reference model, evaluated mid-cycle while all inputs are stable
   always @(negedge clk) begin
      ins_t h;
      rsp_t f;
      bit occ, dok, dokl, rg, alw, vld, fv, fs, xfer, acc, fl;
      cyc++;
      if (reset) begin
         chk("reset_ms_to_ws_valid", 147'(ms_to_ws_valid), 147'(0));
         chk("reset_ms_allowin", 147'(ms_allowin), 147'(1));
         chk("reset_ms_to_ds_bus", 147'(ms_to_ds_bus), 147'(0));
         chk("reset_ms_to_es_bus", 147'(ms_to_es_bus), 147'(0));
         exp_q.delete();
         sram_q.delete();
         head_got = 1'b0;
         acc_flag = 1'b0;
      end else begin
         occ = (exp_q.size() != 0);
         h   = occ ? exp_q[0] : '{default: 0};
         dok = data_sram_data_ok;
         fl  = ex_from_ws;
         dokl = dok && (sram_q.size() != 0) && sram_q[0].live;
         rg   = !h.mem_req || head_got || dokl;
         alw  = !occ || (rg && ws_allowin);
         vld  = occ && rg;
         fv   = occ && h.gr_we && !h.ex && (h.dest != 5'd0);
         fs   = fv && (h.res_from_cp0 || (h.res_from_mem && !rg));
         chk("ms_allowin", 147'(ms_allowin), 147'(alw));
         chk("ms_to_ws_valid", 147'(ms_to_ws_valid), 147'(vld));
         chk("ms_to_es_bus", 147'(ms_to_es_bus), 147'(occ && h.ex));
         chk("fwd_valid_stall", 147'(ms_to_ds_bus[38:37]), 147'({fv, fs}));
         if (fv && !fs) chk("fwd_dest_data", 147'(ms_to_ds_bus[36:0]), 147'({h.dest, fin(h)}));
         xfer = vld && ws_allowin && !fl;
         if (xfer) chk("ms_to_ws_bus", ms_to_ws_bus, ws_bus(h));

         // advance the model across the coming clock edge
         if (dok && (sram_q.size() != 0)) begin
            f = sram_q.pop_front();
            if (f.live) head_got = 1'b1;
         end
         if (xfer) begin
            void'(exp_q.pop_front());
            head_got = 1'b0;
         end
         acc = es_to_ms_valid && alw;
         if (acc) begin
            if (cur.mem_req) sram_q.push_back('{live: !fl, rdata: cur.rdata, issue: cyc, lat: cur.lat});
            if (!fl) exp_q.push_back(cur);
         end
         if (fl) begin
            exp_q.delete();
            head_got = 1'b0;
            foreach (sram_q[i]) sram_q[i].live = 1'b0;
         end
         acc_flag = acc;
      end
   end

   // One cycle of stimulus, applied just after the clock edge
   task automatic drive_cycle(input bit rnd);
      bit fl_now;
      fl_now = (acc_flag && cur.fl == 1);
      if (acc_flag || !es_to_ms_valid) begin
         es_to_ms_valid = 1'b0;
         if (dir_q.size() != 0) begin
            cur = dir_q.pop_front();
            es_to_ms_valid = 1'b1;
         end else if (rnd && $urandom_range(0, 99) >= idle_pct) begin
            cur = rand_ins();
            es_to_ms_valid = 1'b1;
         end
         if (es_to_ms_valid) begin
            es_to_ms_bus = es_bus(cur);
            ws_low = cur.wsl;
         end
      end
      if (es_to_ms_valid && cur.fl == 2) fl_now = 1'b1;
      if (rnd && sram_q.size() <= 1 && $urandom_range(0, 99) < flush_pct) fl_now = 1'b1;
      ex_from_ws = fl_now;
      if (ws_low > 0) begin
         ws_allowin = 1'b0;
         ws_low--;
      end else begin
         ws_allowin = ($urandom_range(0, 99) < ws_pct);
      end
      if (sram_q.size() != 0 && (cyc - sram_q[0].issue) >= sram_q[0].lat) begin
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = sram_q[0].rdata;
      end else begin
         data_sram_data_ok = 1'b0;
         data_sram_rdata   = $urandom;
      end
   endtask

   initial begin
      ins_t i;
      reset = 1'b1;
      ws_allowin = 1'b0;
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'd0;
      ex_from_ws = 1'b0;
      n_chk = 0; n_fail = 0; cyc = 0; ws_low = 0;
      ws_pct = 100; flush_pct = 0; idle_pct = 0; lat_max = 4;
      cur = '{default: 0};
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;

      // load with a 3-cycle response
      i = base(32'h100, 5'd9); i.mem_req = 1; i.res_from_mem = 1; i.gr_we = 1;
      i.rdata = 32'hdead_beef; i.lat = 2; dir_q.push_back(i);
      // load whose response arrives while WB is blocked
      i = base(32'h104, 5'd10); i.mem_req = 1; i.res_from_mem = 1; i.gr_we = 1;
      i.rdata = 32'hdead_beef; i.lat = 0; i.wsl = 3; dir_q.push_back(i);
      // plain ALU results, live and to r0
      i = base(32'h5, 5'd8); i.gr_we = 1; dir_q.push_back(i);
      i = base(32'h7, 5'd0); i.gr_we = 1; dir_q.push_back(i);
      // address-error exception
      i = base(32'h101, 5'd3); i.ex = 1; i.excode = 5'h04; i.gr_we = 1; dir_q.push_back(i);
      // two loads killed by flushes, then a live load behind their responses
      i = base(32'h200, 5'd12); i.mem_req = 1; i.res_from_mem = 1; i.gr_we = 1;
      i.lat = 6; i.fl = 1; dir_q.push_back(i);
      i = base(32'h204, 5'd13); i.mem_req = 1; i.res_from_mem = 1; i.gr_we = 1;
      i.lat = 6; i.fl = 2; dir_q.push_back(i);
      i = base(32'h208, 5'd11); i.mem_req = 1; i.res_from_mem = 1; i.gr_we = 1;
      i.rdata = 32'h1234_5678; i.lat = 0; dir_q.push_back(i);

      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         drive_cycle(1'b0);
         if (dir_q.size() == 0 && !es_to_ms_valid && exp_q.size() == 0 && sram_q.size() == 0) break;
      end

      ws_pct = 70; flush_pct = 4; idle_pct = 20; lat_max = 4;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         drive_cycle(1'b1);
      end

      ws_pct = 100; flush_pct = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         drive_cycle(1'b0);
         if (!es_to_ms_valid && exp_q.size() == 0 && sram_q.size() == 0) break;
      end
      @(negedge clk);
      chk("drain_outstanding", 147'(exp_q.size() + sram_q.size()), 147'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
